// File: rtl/branch_predictor_if.sv
// Resolved-branch feedback bundle from execute to the fetch-side predictor.
// The "in" side is the predictor; the "out" side is the execute stage.
interface branch_feedback_ifc #(
    parameter int PC_SIZE = 16
);
    logic               branch;
    logic [PC_SIZE-1:0] pc;
    logic [PC_SIZE-1:0] predict_target;
    logic [PC_SIZE-1:0] feedback_target;
    logic               predict_taken;
    logic               feedback_taken;

    modport in (
        input branch, pc, predict_target, feedback_target, predict_taken, feedback_taken
    );

    modport out (
        output branch, pc, predict_target, feedback_target, predict_taken, feedback_taken
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency fetch lookup,
// mispredict detection and redirect, table training and saturating statistics.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int STAT_W  = 16,
    parameter int PC_SIZE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_SIZE-1:0] fetch_pc,
    output logic               predict_taken,
    output logic [PC_SIZE-1:0] predict_target,
    branch_feedback_ifc.in     fb,
    output logic               mispredict,
    output logic [PC_SIZE-1:0] redirect_pc,
    output logic [STAT_W-1:0]  branch_count,
    output logic [STAT_W-1:0]  mispredict_count
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_SIZE - IDX;

    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } ctr_t;

    logic               valid_q  [ENTRIES];
    ctr_t               ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_SIZE-1:0] target_q [ENTRIES];

    logic [IDX-1:0]   f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX-1:0]   fb_idx;
    logic [TAG_W-1:0] fb_tag;
    logic             fb_hit;
    logic             fb_active;
    ctr_t             fb_ctr;
    ctr_t             fb_ctr_next;

    assign f_idx  = fetch_pc[IDX-1:0];
    assign f_tag  = fetch_pc[PC_SIZE-1:IDX];
    assign fb_idx = fb.pc[IDX-1:0];
    assign fb_tag = fb.pc[PC_SIZE-1:IDX];

    // Lookup reads registered state only, so a same-cycle update is never bypassed.
    assign f_hit          = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign predict_taken  = !rst && f_hit && ctr_q[f_idx][1];
    assign predict_target = predict_taken ? target_q[f_idx] : fetch_pc + PC_SIZE'(1);

    assign fb_active   = fb.branch && !rst;
    assign fb_hit      = valid_q[fb_idx] && (tag_q[fb_idx] == fb_tag);
    assign fb_ctr      = ctr_q[fb_idx];

    assign mispredict  = fb_active &&
                         ((fb.predict_taken != fb.feedback_taken) ||
                          (fb.feedback_taken && (fb.predict_target != fb.feedback_target)));
    assign redirect_pc = !fb_active          ? '0 :
                         fb.feedback_taken   ? fb.feedback_target :
                                               fb.pc + PC_SIZE'(1);

    always_comb begin
        fb_ctr_next = fb_ctr;
        if (fb.feedback_taken) begin
            if (fb_ctr != CTR_STRONG_T) fb_ctr_next = ctr_t'(fb_ctr + 2'd1);
        end else begin
            if (fb_ctr != CTR_STRONG_NT) fb_ctr_next = ctr_t'(fb_ctr - 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WEAK_NT;
            end
        end else if (fb.branch) begin
            if (fb_hit) begin
                ctr_q[fb_idx] <= fb_ctr_next;
            end else if (fb.feedback_taken) begin
                valid_q[fb_idx] <= 1'b1;
                ctr_q[fb_idx]   <= CTR_WEAK_T;
            end
        end
    end

    // NOTE: tag and target are qualified by valid, so they are left out of reset;
    // keeping them in a reset-free block lets the arrays map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (fb_active && fb.feedback_taken) begin
            tag_q[fb_idx]    <= fb_tag;
            target_q[fb_idx] <= fb.feedback_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (fb.branch && (branch_count != '1))
                branch_count <= branch_count + STAT_W'(1);
            if (mispredict && (mispredict_count != '1))
                mispredict_count <= mispredict_count + STAT_W'(1);
        end
    end
endmodule
